// File: rtl/nor_flash_ctrl_if.sv
// Request/response port between a system bus master and nor_flash_ctrl.
// The master drives the command fields; the controller returns ready and the completion pulse.
interface nor_flash_ctrl_if #(
    parameter int unsigned ADDR_W = 22,
    parameter int unsigned DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/nor_flash_ctrl.sv
// AMD/JEDEC-command parallel NOR flash controller (word mode): read, program and STS polling with timeout.
// Define NOR_FLASH_ERASE_EN to include the sector-erase command sequence (op 10); otherwise op 10 is rejected.
module nor_flash_ctrl #(
    parameter int unsigned ADDR_W    = 22,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned T_ACC     = 3,
    parameter int unsigned T_WP      = 2,
    parameter int unsigned T_WPH     = 1,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    nor_flash_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0] nf_a,
    output logic [DATA_W-1:0] nf_dq_o,
    output logic              nf_dq_oe,
    input  logic [DATA_W-1:0] nf_dq_i,
    output logic              nf_ce_n,
    output logic              nf_oe_n,
    output logic              nf_we_n,
    output logic              nf_rp_n,
    input  logic              nf_sts
);

    localparam int unsigned T_MAX0 = (T_ACC > T_WP) ? T_ACC : T_WP;
    localparam int unsigned T_MAX  = (T_MAX0 > T_WPH) ? T_MAX0 : T_WPH;
    localparam int unsigned CNT_W  = $clog2(T_MAX + 1);
    localparam logic [TIMEOUT_W-1:0] TMO_MAX = '1;

    // Unlock/command tables; the final entry is replaced by the captured address (and data for program).
    localparam logic [11:0] PRG_A [4] = '{12'h555, 12'h2AA, 12'h555, 12'h000};
    localparam logic [7:0]  PRG_D [4] = '{8'hAA, 8'h55, 8'hA0, 8'h00};
`ifdef NOR_FLASH_ERASE_EN
    localparam logic [11:0] ERS_A [6] = '{12'h555, 12'h2AA, 12'h555, 12'h555, 12'h2AA, 12'h000};
    localparam logic [7:0]  ERS_D [6] = '{8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h30};
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ACC, S_WR_SETUP, S_WR_LOW, S_WR_HIGH, S_POLL, S_ABORT, S_ERR
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           step_q, step_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 abort_q, abort_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
`ifdef NOR_FLASH_ERASE_EN
    logic                 erase_q, erase_d;
`endif

    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] nf_a_q, nf_a_d;
    logic [DATA_W-1:0] nf_dq_o_q, nf_dq_o_d;
    logic              nf_dq_oe_q, nf_dq_oe_d;
    logic              nf_ce_n_q, nf_ce_n_d;
    logic              nf_oe_n_q, nf_oe_n_d;
    logic              nf_we_n_q, nf_we_n_d;
    logic              nf_rp_n_q, nf_rp_n_d;

    logic              accept;
    logic [2:0]        last_step;
    logic [2:0]        nxt_step;
    logic [ADDR_W-1:0] tbl_a;
    logic [DATA_W-1:0] tbl_d;

    assign accept = (state_q == S_IDLE) && cmd_ready_q && bus.cmd_valid;

`ifdef NOR_FLASH_ERASE_EN
    assign last_step = erase_q ? 3'd5 : 3'd3;
`else
    assign last_step = 3'd3;
`endif

    // Address/data of the bus write about to be set up
    always_comb begin : step_lookup
        nxt_step = (state_q == S_IDLE) ? 3'd0 : step_q + 3'd1;
        tbl_a    = ADDR_W'(PRG_A[nxt_step[1:0]]);
        tbl_d    = DATA_W'(PRG_D[nxt_step[1:0]]);
`ifdef NOR_FLASH_ERASE_EN
        if (erase_q) begin
            tbl_a = ADDR_W'(ERS_A[nxt_step]);
            tbl_d = DATA_W'(ERS_D[nxt_step]);
        end
`endif
        if (nxt_step == last_step) begin
            tbl_a = addr_q;
`ifdef NOR_FLASH_ERASE_EN
            if (!erase_q) tbl_d = wdata_q;
`else
            tbl_d = wdata_q;
`endif
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        2'b00:   state_d = S_RD_ACC;
                        2'b01:   state_d = S_WR_SETUP;
`ifdef NOR_FLASH_ERASE_EN
                        2'b10:   state_d = S_WR_SETUP;
`endif
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_RD_ACC:   if (cnt_q == '0) state_d = S_IDLE;
            S_WR_SETUP: state_d = S_WR_LOW;
            S_WR_LOW:   if (cnt_q == '0) state_d = S_WR_HIGH;
            S_WR_HIGH: begin
                if (cnt_q == '0) begin
                    if (abort_q)                  state_d = S_IDLE;
                    else if (step_q == last_step) state_d = S_POLL;
                    else                          state_d = S_WR_SETUP;
                end
            end
            // The first two POLL cycles are blanking: STS may not yet reflect the new operation
            S_POLL: begin
                if (tmo_q >= TIMEOUT_W'(2)) begin
                    if (nf_sts)                 state_d = S_IDLE;
                    else if (tmo_q == TMO_MAX)  state_d = S_ABORT;
                end
            end
            S_ABORT: state_d = S_WR_SETUP;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : outputs
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        nf_a_d      = nf_a_q;
        nf_dq_o_d   = nf_dq_o_q;
        nf_dq_oe_d  = state_d inside {S_WR_SETUP, S_WR_LOW, S_WR_HIGH};
        nf_ce_n_d   = !(state_d inside {S_RD_ACC, S_WR_SETUP, S_WR_LOW});
        nf_oe_n_d   = (state_d != S_RD_ACC);
        nf_we_n_d   = (state_d != S_WR_LOW);
        nf_rp_n_d   = 1'b1;
        cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        step_d      = step_q;
        tmo_d       = tmo_q;
        abort_d     = abort_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`ifdef NOR_FLASH_ERASE_EN
        erase_d     = erase_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    step_d  = '0;
                    abort_d = 1'b0;
                    cnt_d   = CNT_W'(T_ACC - 1);
`ifdef NOR_FLASH_ERASE_EN
                    erase_d = (bus.cmd_op == 2'b10);
`endif
                    if (bus.cmd_op == 2'b00) nf_a_d = bus.cmd_addr;
                end
            end
            S_RD_ACC: begin
                if (state_d == S_IDLE) begin
                    rsp_rdata_d = nf_dq_i;
                    rsp_valid_d = 1'b1;
                end
            end
            S_WR_SETUP: cnt_d = CNT_W'(T_WP - 1);
            S_WR_LOW:   if (state_d == S_WR_HIGH) cnt_d = CNT_W'(T_WPH - 1);
            S_WR_HIGH: begin
                if (state_d == S_WR_SETUP) begin
                    step_d = step_q + 3'd1;
                end else if (state_d == S_POLL) begin
                    tmo_d = '0;
                end else if (state_d == S_IDLE) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            S_POLL: begin
                if (state_d == S_IDLE)      rsp_valid_d = 1'b1;
                else if (tmo_q != TMO_MAX)  tmo_d = tmo_q + TIMEOUT_W'(1);
            end
            S_ABORT: abort_d = 1'b1;
            S_ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            default: ;
        endcase
        if (state_d == S_WR_SETUP) begin
            if (state_q == S_ABORT) begin
                nf_a_d    = '0;
                nf_dq_o_d = DATA_W'(16'h00F0);
            end else begin
                nf_a_d    = tbl_a;
                nf_dq_o_d = tbl_d;
            end
        end
    end

    always_ff @(posedge clk) begin : regs
        if (reset) begin
            cnt_q       <= '0;
            step_q      <= '0;
            tmo_q       <= '0;
            abort_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
`ifdef NOR_FLASH_ERASE_EN
            erase_q     <= 1'b0;
`endif
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            nf_a_q      <= '0;
            nf_dq_o_q   <= '0;
            nf_dq_oe_q  <= 1'b0;
            nf_ce_n_q   <= 1'b1;
            nf_oe_n_q   <= 1'b1;
            nf_we_n_q   <= 1'b1;
            nf_rp_n_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            tmo_q       <= tmo_d;
            abort_q     <= abort_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
`ifdef NOR_FLASH_ERASE_EN
            erase_q     <= erase_d;
`endif
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            nf_a_q      <= nf_a_d;
            nf_dq_o_q   <= nf_dq_o_d;
            nf_dq_oe_q  <= nf_dq_oe_d;
            nf_ce_n_q   <= nf_ce_n_d;
            nf_oe_n_q   <= nf_oe_n_d;
            nf_we_n_q   <= nf_we_n_d;
            nf_rp_n_q   <= nf_rp_n_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign nf_a          = nf_a_q;
    assign nf_dq_o       = nf_dq_o_q;
    assign nf_dq_oe      = nf_dq_oe_q;
    assign nf_ce_n       = nf_ce_n_q;
    assign nf_oe_n       = nf_oe_n_q;
    assign nf_we_n       = nf_we_n_q;
    assign nf_rp_n       = nf_rp_n_q;

endmodule

// File: tb/tb_nor_flash_ctrl.sv
// Directed self-checking bench for nor_flash_ctrl with a small behavioural flash (read data, STS busy).
// Define NOR_FLASH_ERASE_EN for both files to exercise the erase sequence.
module tb_nor_flash_ctrl;
    localparam int unsigned ADDR_W = 22;
    localparam int unsigned DATA_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nor_flash_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [ADDR_W-1:0] nf_a;
    logic [DATA_W-1:0] nf_dq_o, nf_dq_i;
    logic nf_dq_oe, nf_ce_n, nf_oe_n, nf_we_n, nf_rp_n, nf_sts;

    nor_flash_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_ACC(3), .T_WP(2), .T_WPH(1), .TIMEOUT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .nf_a(nf_a), .nf_dq_o(nf_dq_o), .nf_dq_oe(nf_dq_oe), .nf_dq_i(nf_dq_i),
        .nf_ce_n(nf_ce_n), .nf_oe_n(nf_oe_n), .nf_we_n(nf_we_n), .nf_rp_n(nf_rp_n),
        .nf_sts(nf_sts)
    );

    // Flash model: fixed word at 0x01234, address-derived data elsewhere; busy 10 cycles after WE# activity
    int busy = 0;
    bit stuck = 1'b0;
    assign nf_dq_i = (nf_a == 22'h01234) ? 16'hBEEF : (nf_a[15:0] ^ 16'hA5A5);
    always @(posedge clk) begin
        if (!nf_we_n)      busy <= 10;
        else if (busy > 0) busy <= busy - 1;
    end
    assign nf_sts = !stuck && (busy == 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: logs each completed write and each response
    int n_wr = 0, we_run = 0, oe_low = 0, strobes = 0, rsp_cnt = 0;
    logic [ADDR_W-1:0] log_a [64];
    logic [DATA_W-1:0] log_d [64];
    int                log_w [64];
    logic              log_oe [64];
    logic [DATA_W-1:0] rsp_d [64];
    logic              rsp_e [64];
    logic              rsp_rdy [64];
    logic              rsp_sp [64];
    int                rsp_cy [64];
    logic we_prev = 1'b1;
    logic sts_prev = 1'b1;
    always @(negedge clk) begin
        if (!nf_we_n) begin
            we_run++;
        end else if (!we_prev) begin
            if (n_wr < 64) begin
                log_a[n_wr] = nf_a;  log_d[n_wr] = nf_dq_o;
                log_w[n_wr] = we_run; log_oe[n_wr] = nf_dq_oe;
                n_wr++;
            end
            we_run = 0;
        end
        we_prev = nf_we_n;
        if (!nf_oe_n) oe_low++;
        if (!nf_ce_n || !nf_oe_n || !nf_we_n) strobes++;
        if (bus.rsp_valid && rsp_cnt < 64) begin
            rsp_d[rsp_cnt] = bus.rsp_rdata; rsp_e[rsp_cnt] = bus.rsp_err;
            rsp_rdy[rsp_cnt] = bus.cmd_ready; rsp_sp[rsp_cnt] = sts_prev;
            rsp_cy[rsp_cnt] = cyc;
            rsp_cnt++;
        end
        sts_prev = nf_sts;
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit hold, output int acc);
        bit ok = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_wdata = d;
        for (int i = 0; i < 200; i++) begin
            if (bus.cmd_ready) begin ok = 1'b1; break; end
            tick();
        end
        chk("accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) begin
            bus.cmd_valid = 1'b0; bus.cmd_addr = '1; bus.cmd_wdata = '1;
        end
    endtask

    task automatic wait_rsp(input int until_cnt, input int budget);
        for (int i = 0; i < budget && rsp_cnt < until_cnt; i++) tick();
        chk("rsp_seen", 32'(rsp_cnt >= until_cnt), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1);
    end

    initial begin
        int acc, acc2, r0, w0, o0, s0;
        bit found;
        logic [ADDR_W-1:0] pa [4];
        logic [DATA_W-1:0] pd [4];
        pa = '{22'h555, 22'h2AA, 22'h555, 22'h00100};
        pd = '{16'h00AA, 16'h0055, 16'h00A0, 16'h5A5A};

        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        repeat (3) tick();
        chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_addr_dq", {nf_a[15:0], nf_dq_o}, 32'd0);
        chk("rst_strobes", {27'd0, nf_dq_oe, nf_ce_n, nf_oe_n, nf_we_n, nf_rp_n}, 32'b01110);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst_rp_n", 32'(nf_rp_n), 32'd1);

        // Single read
        o0 = oe_low; r0 = rsp_cnt;
        send(2'b00, 22'h01234, 16'h0, 1'b0, acc);
        wait_rsp(r0 + 1, 50);
        chk("rd_latency", 32'(rsp_cy[r0] - acc), 32'd3);
        chk("rd_oe_width", 32'(oe_low - o0), 32'd3);
        chk("rd_data", 32'(rsp_d[r0]), 32'hBEEF);
        chk("rd_err", 32'(rsp_e[r0]), 32'd0);
        chk("rd_hold", 32'(bus.rsp_rdata), 32'hBEEF);

        // Program with STS busy after the command sequence
        w0 = n_wr; r0 = rsp_cnt;
        send(2'b01, 22'h00100, 16'h5A5A, 1'b0, acc);
        wait_rsp(r0 + 1, 200);
        chk("pg_nwr", 32'(n_wr - w0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("pg_addr", 32'(log_a[w0 + i]), 32'(pa[i]));
            chk("pg_data", 32'(log_d[w0 + i]), 32'(pd[i]));
            chk("pg_we_width", 32'(log_w[w0 + i]), 32'd2);
            chk("pg_dq_oe", 32'(log_oe[w0 + i]), 32'd1);
        end
        chk("pg_err", 32'(rsp_e[r0]), 32'd0);
        chk("pg_sts_before_rsp", 32'(rsp_sp[r0]), 32'd1);
        chk("pg_rdata_kept", 32'(bus.rsp_rdata), 32'hBEEF);
        chk("pg_dq_oe_off", 32'(nf_dq_oe), 32'd0);

        // Sector erase
        w0 = n_wr; r0 = rsp_cnt; s0 = strobes;
        send(2'b10, 22'h10000, 16'h0, 1'b0, acc);
        wait_rsp(r0 + 1, 200);
`ifdef NOR_FLASH_ERASE_EN
        chk("er_nwr", 32'(n_wr - w0), 32'd6);
        chk("er_addr3", 32'(log_a[w0 + 3]), 32'h555);
        chk("er_data2", 32'(log_d[w0 + 2]), 32'h0080);
        chk("er_last", {log_a[w0 + 5][15:0], log_d[w0 + 5]}, 32'h0000_0030);
        chk("er_last_hi", 32'(log_a[w0 + 5]), 32'h10000);
        chk("er_err", 32'(rsp_e[r0]), 32'd0);
`else
        tick(); tick();
        chk("er_latency", 32'(rsp_cy[r0] - acc), 32'd1);
        chk("er_err", 32'(rsp_e[r0]), 32'd1);
        chk("er_strobes", 32'(strobes - s0), 32'd0);
        chk("er_nwr", 32'(n_wr - w0), 32'd0);
`endif

        // Reserved op
        r0 = rsp_cnt; s0 = strobes;
        send(2'b11, 22'h00042, 16'h0, 1'b0, acc);
        wait_rsp(r0 + 1, 20);
        tick();
        chk("rsv_latency", 32'(rsp_cy[r0] - acc), 32'd1);
        chk("rsv_err", 32'(rsp_e[r0]), 32'd1);
        chk("rsv_strobes", 32'(strobes - s0), 32'd0);

        // STS stuck low: timeout, abort write, error response
        stuck = 1'b1;
        w0 = n_wr; r0 = rsp_cnt;
        send(2'b01, 22'h00200, 16'h1234, 1'b0, acc);
        wait_rsp(r0 + 1, 300);
        chk("to_nwr", 32'(n_wr - w0), 32'd5);
        chk("to_abort_write", {log_a[w0 + 4][15:0], log_d[w0 + 4]}, 32'h0000_00F0);
        chk("to_err", 32'(rsp_e[r0]), 32'd1);
        chk("to_ready", 32'(rsp_rdy[r0]), 32'd1);
        chk("to_rdata_kept", 32'(bus.rsp_rdata), 32'hBEEF);
        stuck = 1'b0;

        // Reset during WR_LOW of the second write step
        w0 = n_wr;
        send(2'b01, 22'h00300, 16'hABCD, 1'b0, acc);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ((n_wr - w0) == 1 && !nf_we_n) begin found = 1'b1; break; end
            tick();
        end
        chk("rst_mid_reached", 32'(found), 32'd1);
        r0 = rsp_cnt;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_strobes", {28'd0, nf_we_n, nf_ce_n, nf_dq_oe, nf_rp_n}, 32'b1100);
        chk("rst_mid_rsp", 32'(bus.rsp_valid), 32'd0);
        tick(); tick();
        reset = 1'b0;
        repeat (40) tick();
        chk("rst_mid_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        chk("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);

        // Two reads queued with cmd_valid held throughout
        r0 = rsp_cnt;
        send(2'b00, 22'h00010, 16'h0, 1'b1, acc);
        send(2'b00, 22'h00020, 16'h0, 1'b0, acc2);
        wait_rsp(r0 + 2, 50);
        repeat (10) tick();
        chk("q_count", 32'(rsp_cnt - r0), 32'd2);
        chk("q_data0", 32'(rsp_d[r0]), 32'hA5B5);
        chk("q_data1", 32'(rsp_d[r0 + 1]), 32'hA585);
        chk("q_spacing", 32'(acc2 - acc), 32'd4);
        chk("q_accept_after_rsp", 32'(acc2 - rsp_cy[r0]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
